dual_frame_buffer_param: RTL
============================

Name: dual_frame_buffer_param

Overview:
Parametrised double-buffered frame store between the sprite renderer (write side) and the VGA scan-out (read side). The renderer draws into the back buffer while scan-out reads the front buffer. A renderer-requested swap is committed only at the start of vertical blanking. Adds transparent-key write masking, an optional back-buffer clear after each swap, and out-of-range read/write handling.

Parameters:
H_RES, 24, frame width in pixels
V_RES, 45, frame height in pixels
PIX_W, 5, encoded pixel width (palette index)
COORD_W, 10, width of X/Y coordinate ports
TRANSPARENT_KEY, 5'h15, WrPixel value that suppresses the write
BG_VAL, 0, PixelOut value for out-of-range reads
CLEAR_ON_SWAP, 1, 1 = clear the new back buffer to CLEAR_VAL after each swap
CLEAR_VAL, 0, fill value used by the clear sweep

Ports:
Clk  in  1  system clock; all logic on posedge
Reset_n  in  1  reset, synchronous, active-low
VS  in  1  vertical sync from the VGA controller, active-low
DrawX  in  COORD_W  scan-out X coordinate
DrawY  in  COORD_W  scan-out Y coordinate
WrX  in  COORD_W  renderer write X coordinate
WrY  in  COORD_W  renderer write Y coordinate
WrPixel  in  PIX_W  renderer pixel data
WrEn  in  1  renderer write strobe
SwapReq  in  1  level request to swap buffers at the next vblank
SwapAck  out  1  one-cycle pulse on the cycle the swap commits
WrReady  out  1  writes accepted (low while pending or clearing)
FrontSel  out  1  0 = buffer A is front, 1 = buffer B is front
PixelOut  out  PIX_W  front-buffer pixel, registered
PixelValid  out  1  registered flag: DrawX/DrawY were in range

Behaviour:
- DEPTH = H_RES*V_RES; ADDR_W = $clog2(DEPTH); address = y*H_RES + x, computed at ADDR_W bits.
- Reset (Reset_n=0 at posedge) sets: state IDLE, FrontSel=0, SwapAck=0, WrReady=1, PixelOut=BG_VAL, PixelValid=0, VS_d=1, clear counter=0. Memory contents are not reset.
- Reset asserted mid-clear or mid-pending aborts the operation. The pending request is dropped.
- Read path, latency 1: PixelOut(n+1) = front[addr(DrawX,DrawY)(n)] when DrawX<H_RES and DrawY<V_RES; otherwise BG_VAL. PixelValid(n+1) is the in-range flag. The front buffer used is the one selected by FrontSel(n).
- Write path: the back buffer is written at addr(WrX,WrY) only when all of the following hold:
  - WrEn=1 and WrReady=1
  - WrX<H_RES and WrY<V_RES
  - WrPixel != TRANSPARENT_KEY
  All other writes are dropped silently. The read and write ports never target the same buffer.
- Vblank detect: VS_d registers VS. vb_start = VS_d & ~VS (falling edge of VS).
- FSM states:
  - IDLE: WrReady=1. If SwapReq=1, go to PENDING.
  - PENDING: WrReady=0. On vb_start: toggle FrontSel, pulse SwapAck for 1 cycle, then go to CLEARING if CLEAR_ON_SWAP else IDLE.
  - CLEARING: WrReady=0. Each cycle write CLEAR_VAL to back[cnt], cnt++. After cnt=DEPTH-1 is written, reset cnt to 0 and go to IDLE. Takes exactly DEPTH cycles.
- A write on the cycle IDLE->PENDING is accepted. It uses the pre-swap back buffer, which becomes the front.
- SwapReq is sampled only in IDLE. Holding it high re-requests a swap after returning to IDLE; the renderer deasserts it on SwapAck.
- vb_start in IDLE or CLEARING has no effect. Clearing continues across vblank.
- If VS is held low at reset, no vb_start fires until VS goes 1 then 0.

Decomposition:
- Package frame_buffer_pkg holds:
  - fb_state_t enum {IDLE, PENDING, CLEARING}
  - default parameter constants
  - an addr_of() function
- Sub-module fb_ram: simple dual-port RAM, DEPTH x PIX_W, with one write port and one registered read port. It is instantiated twice (buffer A and buffer B). Top-level muxes route write/clear and read to the correct instance by FrontSel.

Test Plan:
1. Reset_n=0 for 2 cycles, then 1: FrontSel=0, WrReady=1, SwapAck=0, PixelOut=0, PixelValid=0.
2. Transparent key and read latency:
   - Write WrX=3, WrY=2, WrPixel=5'h07, then WrPixel=5'h15 to the same address; swap on a VS falling edge.
   - Drive DrawX=3, DrawY=2: PixelOut=5'h07 one cycle later. The keyed write is dropped.
3. Swap timing: SwapReq=1 with VS high for 10 cycles -> WrReady=0, no SwapAck. VS falls -> SwapAck=1 for exactly 1 cycle and FrontSel toggles 0->1 on that cycle.
4. Clear sweep (CLEAR_ON_SWAP=1, CLEAR_VAL=0):
   - After the swap, WrReady stays 0 for exactly 1080 cycles; WrEn during this window is ignored.
   - Swap back: every address reads 0 except addresses rendered post-clear.
5. Out of range: DrawX=24, DrawY=0 -> PixelOut=BG_VAL, PixelValid=0. A write to WrX=0, WrY=45 leaves all 1080 locations unchanged.
6. Reset mid-operation: assert Reset_n=0 at clear cycle 500 -> next cycle FrontSel=0, state IDLE, WrReady=1. VS falls with SwapReq=0 -> no SwapAck.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// Shared types, default geometry and address helper for the double-buffered frame store.
package frame_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        CLEARING
    } fb_state_t;

    localparam int DEF_H_RES           = 24;
    localparam int DEF_V_RES           = 45;
    localparam int DEF_PIX_W           = 5;
    localparam int DEF_COORD_W         = 10;
    localparam int DEF_TRANSPARENT_KEY = 21;
    localparam int DEF_BG_VAL          = 0;
    localparam bit DEF_CLEAR_ON_SWAP   = 1'b1;
    localparam int DEF_CLEAR_VAL       = 0;

    // Row-major linear address; callers truncate to their address width.
    function automatic logic [31:0] addr_of(input logic [31:0] x, input logic [31:0] y,
                                            input int hres);
        return y * 32'(hres) + x;
    endfunction

endpackage

// File: rtl/dual_frame_buffer_param_fb_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module fb_ram #(
    parameter int DEPTH  = 1080,
    parameter int PIX_W  = 5,
    parameter int ADDR_W = 11
) (
    input  logic              Clk,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [PIX_W-1:0]  WrData,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [PIX_W-1:0]  RdData
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (WrEn) begin
            mem[WrAddr] <= WrData;
        end
        RdData <= mem[RdAddr];
    end

endmodule

// File: rtl/dual_frame_buffer_param.sv
// Double-buffered frame store: renderer writes the back buffer, scan-out reads the front,
// swaps commit on the falling edge of VS, optionally followed by a back-buffer clear sweep.
module dual_frame_buffer_param
    import frame_buffer_pkg::*;
#(
    parameter int               H_RES           = DEF_H_RES,
    parameter int               V_RES           = DEF_V_RES,
    parameter int               PIX_W           = DEF_PIX_W,
    parameter int               COORD_W         = DEF_COORD_W,
    parameter logic [PIX_W-1:0] TRANSPARENT_KEY = PIX_W'(DEF_TRANSPARENT_KEY),
    parameter logic [PIX_W-1:0] BG_VAL          = PIX_W'(DEF_BG_VAL),
    parameter bit               CLEAR_ON_SWAP   = DEF_CLEAR_ON_SWAP,
    parameter logic [PIX_W-1:0] CLEAR_VAL       = PIX_W'(DEF_CLEAR_VAL)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               VS,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic [COORD_W-1:0] WrX,
    input  logic [COORD_W-1:0] WrY,
    input  logic [PIX_W-1:0]   WrPixel,
    input  logic               WrEn,
    input  logic               SwapReq,
    output logic               SwapAck,
    output logic               WrReady,
    output logic               FrontSel,
    output logic [PIX_W-1:0]   PixelOut,
    output logic               PixelValid
);

    localparam int                 DEPTH     = H_RES * V_RES;
    localparam int                 ADDR_W    = $clog2(DEPTH);
    localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(V_RES);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

    fb_state_t         stateReg, stateNext;
    logic              frontSelReg, frontSelNext;
    logic              swapAckReg, swapAckNext;
    logic [ADDR_W-1:0] clrCntReg, clrCntNext;
    logic              vsDelayReg;
    logic              pixelValidReg;
    logic              rdSelReg;
    logic              wrReady;

    logic              vbStart;
    logic              rdInRange, wrInRange, wrAccept, clearing;
    logic [ADDR_W-1:0] rdAddr, wrAddr;
    logic              backWe;
    logic [ADDR_W-1:0] backAddr;
    logic [PIX_W-1:0]  backData;
    logic [PIX_W-1:0]  ramRdData [2];

    assign vbStart   = vsDelayReg & ~VS;
    assign rdInRange = (DrawX < X_LIM) && (DrawY < Y_LIM);
    assign wrInRange = (WrX < X_LIM) && (WrY < Y_LIM);
    assign rdAddr    = ADDR_W'(addr_of(32'(DrawX), 32'(DrawY), H_RES));
    assign wrAddr    = ADDR_W'(addr_of(32'(WrX), 32'(WrY), H_RES));
    assign clearing  = (stateReg == CLEARING);
    assign wrAccept  = WrEn && wrReady && wrInRange && (WrPixel != TRANSPARENT_KEY);

    // Reset gates the write port so an aborted clear leaves no trailing write.
    assign backWe   = Reset_n && (clearing || wrAccept);
    assign backAddr = clearing ? clrCntReg : wrAddr;
    assign backData = clearing ? CLEAR_VAL : WrPixel;

    always_comb begin
        stateNext    = stateReg;
        frontSelNext = frontSelReg;
        swapAckNext  = 1'b0;
        clrCntNext   = clrCntReg;
        wrReady      = 1'b0;
        case (stateReg)
            IDLE: begin
                wrReady = 1'b1;
                if (SwapReq) begin
                    stateNext = PENDING;
                end
            end
            PENDING: begin
                if (vbStart) begin
                    frontSelNext = ~frontSelReg;
                    swapAckNext  = 1'b1;
                    stateNext    = CLEAR_ON_SWAP ? CLEARING : IDLE;
                end
            end
            CLEARING: begin
                if (clrCntReg == LAST_ADDR) begin
                    clrCntNext = '0;
                    stateNext  = IDLE;
                end else begin
                    clrCntNext = clrCntReg + ADDR_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            stateReg      <= IDLE;
            frontSelReg   <= 1'b0;
            swapAckReg    <= 1'b0;
            clrCntReg     <= '0;
            vsDelayReg    <= 1'b1;
            pixelValidReg <= 1'b0;
            rdSelReg      <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            frontSelReg   <= frontSelNext;
            swapAckReg    <= swapAckNext;
            clrCntReg     <= clrCntNext;
            vsDelayReg    <= VS;
            pixelValidReg <= rdInRange;
            rdSelReg      <= frontSelReg;
        end
    end

    // Buffer gi is written only while it is the back buffer; both share the read address.
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        fb_ram #(
            .DEPTH (DEPTH),
            .PIX_W (PIX_W),
            .ADDR_W(ADDR_W)
        ) u_ram (
            .Clk   (Clk),
            .WrEn  (backWe && (frontSelReg != 1'(gi))),
            .WrAddr(backAddr),
            .WrData(backData),
            .RdAddr(rdInRange ? rdAddr : '0),
            .RdData(ramRdData[gi])
        );
    end

    assign SwapAck    = swapAckReg;
    assign WrReady    = wrReady;
    assign FrontSel   = frontSelReg;
    assign PixelValid = pixelValidReg;
    assign PixelOut   = pixelValidReg ? ramRdData[rdSelReg] : BG_VAL;

endmodule
